reg_file_sb: RTL and testbench

Parametrised, scoreboarded register file for the pipelined core. It has two asynchronous read ports, two write-back ports with fixed priority, and optional write-to-read bypass. A per-register busy scoreboard is set at issue, cleared at write-back and bulk-cleared on flush. Decode uses the busy flags to detect RAW hazards and stall.

---
 rtl/reg_file_sb.sv | 115 +++++++++++
 tb/tb_reg_file_sb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two combinational read ports, two prioritised write-back
// ports, optional write-to-read bypass, and a per-register busy vector for RAW stalls.
module reg_file_sb #(
    parameter int unsigned N      = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [N-1:0]      rd_data1_o,
    output logic [N-1:0]      rd_data2_o,
    output logic              rd_busy1_o,
    output logic              rd_busy2_o,
    input  logic              wr_en0_i,
    input  logic [ADDR_W-1:0] wr_addr0_i,
    input  logic [N-1:0]      wr_data0_i,
    input  logic              wr_en1_i,
    input  logic [ADDR_W-1:0] wr_addr1_i,
    input  logic [N-1:0]      wr_data1_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_cnt_o
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [N-1:0]     regs_q [DEPTH];
    logic [N-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Address 0 and addresses beyond DEPTH behave as the hardwired-zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic wb_hit(input logic [ADDR_W-1:0] a);
        return (wr_en1_i && (wr_addr1_i == a)) || (wr_en0_i && (wr_addr0_i == a));
    endfunction

    function automatic logic [N-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [N-1:0] v;
        v = '0;
        if (addr_ok(a)) begin
            v = regs_q[a];
            if (BYPASS != 0) begin
                if (wr_en1_i && (wr_addr1_i == a)) begin
                    v = wr_data1_i;
                end else if (wr_en0_i && (wr_addr0_i == a)) begin
                    v = wr_data0_i;
                end
            end
        end
        return v;
    endfunction

    function automatic logic rd_bsy(input logic [ADDR_W-1:0] a);
        logic b;
        b = 1'b0;
        if (addr_ok(a)) begin
            b = busy_q[a] && !((BYPASS != 0) && wb_hit(a));
        end
        return b;
    endfunction

    always_comb begin
        rd_data1_o = rd_val(rd_addr1_i);
        rd_data2_o = rd_val(rd_addr2_i);
        rd_busy1_o = rd_bsy(rd_addr1_i);
        rd_busy2_o = rd_bsy(rd_addr2_i);
    end

    // Order per register: flush, then write-back clear, then issue set (issue wins).
    always_comb begin
        busy_d    = flush_i ? '0 : busy_q;
        busy_d[0] = 1'b0;
        regs_d    = regs_q;
        regs_d[0] = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (wr_en0_i && (wr_addr0_i == ADDR_W'(r))) begin
                regs_d[r] = wr_data0_i;
                busy_d[r] = 1'b0;
            end
            if (wr_en1_i && (wr_addr1_i == ADDR_W'(r))) begin
                regs_d[r] = wr_data1_i;
                busy_d[r] = 1'b0;
            end
            if (iss_en_i && (iss_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_cnt_o = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            busy_cnt_o = busy_cnt_o + {{ADDR_W{1'b0}}, busy_q[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: two DUT builds (32 entries with bypass, 24 entries without) share
// stimulus; a queue of expected outputs is drained by an independent monitor.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr0, wr_addr1, iss_addr;
    logic [31:0] wr_data0, wr_data1;
    logic        wr_en0, wr_en1, iss_en, flush;

    logic [31:0] d1a, d2a, d1b, d2b;
    logic        b1a, b2a, b1b, b2b;
    logic [5:0]  ca, cb;

    always #5 clk = ~clk;

    reg_file_sb #(.N(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(d1a), .rd_data2_o(d2a), .rd_busy1_o(b1a), .rd_busy2_o(b2a),
        .wr_en0_i(wr_en0), .wr_addr0_i(wr_addr0), .wr_data0_i(wr_data0),
        .wr_en1_i(wr_en1), .wr_addr1_i(wr_addr1), .wr_data1_i(wr_data1),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush), .busy_cnt_o(ca)
    );

    reg_file_sb #(.N(32), .DEPTH(24), .ADDR_W(5), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(d1b), .rd_data2_o(d2b), .rd_busy1_o(b1b), .rd_busy2_o(b2b),
        .wr_en0_i(wr_en0), .wr_addr0_i(wr_addr0), .wr_data0_i(wr_data0),
        .wr_en1_i(wr_en1), .wr_addr1_i(wr_addr1), .wr_data1_i(wr_data1),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush), .busy_cnt_o(cb)
    );

    typedef struct {
        logic [31:0] d1a, d2a, d1b, d2b;
        logic        b1a, b2a, b1b, b2b;
        logic [5:0]  ca, cb;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [32];
    bit          bsy [32];

    // Reference model: a plain array of values and busy flags, limit = register count.
    function automatic logic [31:0] m_rd(int a, int lim, bit byp);
        if (a == 0 || a >= lim) return 32'h0;
        if (byp && wr_en1 && int'(wr_addr1) == a) return wr_data1;
        if (byp && wr_en0 && int'(wr_addr0) == a) return wr_data0;
        return mem[a];
    endfunction

    function automatic logic m_busy(int a, int lim, bit byp);
        if (a == 0 || a >= lim) return 1'b0;
        if (byp && ((wr_en1 && int'(wr_addr1) == a) || (wr_en0 && int'(wr_addr0) == a))) return 1'b0;
        return bsy[a];
    endfunction

    function automatic logic [5:0] m_cnt(int lim);
        int n = 0;
        for (int i = 1; i < lim; i++) n += int'(bsy[i]);
        return 6'(n);
    endfunction

    task automatic idle();
        rst = 0; wr_en0 = 0; wr_en1 = 0; iss_en = 0; flush = 0;
        wr_addr0 = 0; wr_addr1 = 0; iss_addr = 0; wr_data0 = 0; wr_data1 = 0;
        rd_addr1 = 0; rd_addr2 = 0;
    endtask

    // Inputs are already applied: record expected outputs, advance the model, clock.
    task automatic cycle();
        exp_t e;
        int   a1 = int'(rd_addr1);
        int   a2 = int'(rd_addr2);
        e.d1a = m_rd(a1, 32, 1); e.d2a = m_rd(a2, 32, 1);
        e.d1b = m_rd(a1, 24, 0); e.d2b = m_rd(a2, 24, 0);
        e.b1a = m_busy(a1, 32, 1); e.b2a = m_busy(a2, 32, 1);
        e.b1b = m_busy(a1, 24, 0); e.b2b = m_busy(a2, 24, 0);
        e.ca = m_cnt(32); e.cb = m_cnt(24);
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin mem[i] = 0; bsy[i] = 0; end
        end else begin
            if (flush) for (int i = 0; i < 32; i++) bsy[i] = 0;
            if (wr_en0 && wr_addr0 != 0) begin mem[wr_addr0] = wr_data0; bsy[wr_addr0] = 0; end
            if (wr_en1 && wr_addr1 != 0) begin mem[wr_addr1] = wr_data1; bsy[wr_addr1] = 0; end
            if (iss_en && iss_addr != 0) bsy[iss_addr] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_data1_a", d1a, e.d1a); chk("rd_data2_a", d2a, e.d2a);
                chk("rd_data1_b", d1b, e.d1b); chk("rd_data2_b", d2b, e.d2b);
                chk("rd_busy1_a", 32'(b1a), 32'(e.b1a)); chk("rd_busy2_a", 32'(b2a), 32'(e.b2a));
                chk("rd_busy1_b", 32'(b1b), 32'(e.b1b)); chk("rd_busy2_b", 32'(b2b), 32'(e.b2b));
                chk("busy_cnt_a", 32'(ca), 32'(e.ca)); chk("busy_cnt_b", 32'(cb), 32'(e.cb));
            end
        end
    end

    initial begin : stim
        idle();
        rst = 1;
        for (int i = 0; i < 32; i++) begin mem[i] = 0; bsy[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        // Reset clears storage
        idle(); wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'hDEADBEEF; rd_addr1 = 5; cycle();
        idle(); rd_addr1 = 5; iss_en = 1; iss_addr = 5; cycle();
        idle(); rst = 1; rd_addr1 = 5; rd_addr2 = 5; cycle();
        idle(); rd_addr1 = 5; rd_addr2 = 5; cycle();
        // Port priority on the same address
        idle(); wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'h11;
        wr_en1 = 1; wr_addr1 = 7; wr_data1 = 32'h22; rd_addr1 = 7; cycle();
        idle(); rd_addr1 = 7; cycle();
        // Register 0 is immutable
        idle(); wr_en1 = 1; wr_addr1 = 0; wr_data1 = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; rd_addr1 = 0; cycle();
        idle(); rd_addr1 = 0; rd_addr2 = 0; cycle();
        // Issue then write-back
        idle(); iss_en = 1; iss_addr = 3; cycle();
        idle(); rd_addr1 = 3; cycle();
        idle(); wr_en1 = 1; wr_addr1 = 3; wr_data1 = 32'h5; rd_addr1 = 3; rd_addr2 = 3; cycle();
        idle(); rd_addr1 = 3; cycle();
        // Issue and write-back collide
        idle(); iss_en = 1; iss_addr = 9; wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'hA; rd_addr1 = 9; cycle();
        idle(); rd_addr1 = 9; cycle();
        // Flush with a surviving issue
        idle(); wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'hA; cycle();
        idle(); iss_en = 1; iss_addr = 1; cycle();
        idle(); iss_en = 1; iss_addr = 2; cycle();
        idle(); iss_en = 1; iss_addr = 4; rd_addr1 = 2; cycle();
        idle(); flush = 1; iss_en = 1; iss_addr = 6; rd_addr1 = 1; rd_addr2 = 7; cycle();
        idle(); rd_addr1 = 6; rd_addr2 = 9; cycle();
        // Addresses beyond the 24-entry build
        idle(); wr_en0 = 1; wr_addr0 = 26; wr_data0 = 32'h1234; iss_en = 1; iss_addr = 27; rd_addr1 = 26; cycle();
        idle(); rd_addr1 = 26; rd_addr2 = 27; cycle();
        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rst      = ($urandom_range(0, 79) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            wr_en0   = $urandom_range(0, 1) == 1;
            wr_en1   = $urandom_range(0, 2) == 0;
            iss_en   = $urandom_range(0, 1) == 1;
            wr_addr0 = 5'($urandom_range(0, 31));
            wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
            iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 2) == 0) ? iss_addr : 5'($urandom_range(0, 31));
            cycle();
        end
        idle();
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
